segment_to_binary: RTL and testbench

SEGMENT_TO_BINARY -- requirements
Module: segment_to_binary

---
 rtl/segment_to_binary.sv | 151 +++++++++++++++
 tb/tb_segment_to_binary.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/segment_to_binary.sv
// Recovers per-digit codes from a multiplexed 7-segment display drive.
// Each anode/cathode pair must be stable for STABLE_CYCLES samples before its digit is captured.
module segment_to_binary #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [19:0] codes_out,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        bad_pattern,
  output logic        anode_err
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {ST_WAIT, ST_TRACK, ST_HELD} state_t;

  state_t      state_q, state_d;
  logic [10:0] sample_q, prev_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] codes_q, codes_d;
  logic [3:0]  valid_q, valid_d;
  logic        frame_q, frame_d;
  logic        bad_q, bad_d;
  logic        aerr_q, aerr_d;

  logic        changed;
  logic        capture;
  logic [3:0]  sel;
  logic        one_hot;
  logic [4:0]  code;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 5'd0;
      7'b1001111: decode = 5'd1;
      7'b0010010: decode = 5'd2;
      7'b0000110: decode = 5'd3;
      7'b1001100: decode = 5'd4;
      7'b0100100: decode = 5'd5;
      7'b0100000: decode = 5'd6;
      7'b0001111: decode = 5'd7;
      7'b0000000: decode = 5'd8;
      7'b0000100: decode = 5'd9;
      7'b0001000: decode = 5'd10;
      7'b1100000: decode = 5'd11;
      7'b0110001: decode = 5'd12;
      7'b1000010: decode = 5'd13;
      7'b0110000: decode = 5'd14;
      7'b0111000: decode = 5'd15;
      7'b1110001: decode = 5'd16;
      7'b1111110: decode = 5'd17;
      7'b1111111: decode = 5'd18;
      7'b0011000: decode = 5'd19;
      7'b1101010: decode = 5'd20;
      7'b1001000: decode = 5'd21;
      7'b1000001: decode = 5'd22;
      7'b0111001: decode = 5'd23;
      default:    decode = 5'd31;
    endcase
  endfunction

  // Change detection compares two registered samples, so raw pins never feed logic directly.
  assign changed = (sample_q != prev_q);
  assign sel     = ~sample_q[10:7];
  assign one_hot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign code    = decode(sample_q[6:0]);

  always_comb begin
    if (changed)
      cnt_d = 4'd1;
    else if (cnt_q >= STABLE)
      cnt_d = STABLE;
    else
      cnt_d = cnt_q + 4'd1;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_WAIT:  if (changed) state_d = ST_TRACK;
      ST_TRACK: begin
        if (changed) begin
          state_d = ST_TRACK;
        end else if (cnt_d == STABLE) begin
          state_d = ST_HELD;
          capture = 1'b1;
        end
      end
      ST_HELD:  if (changed) state_d = ST_TRACK;
      default:  state_d = ST_WAIT;
    endcase
  end

  // A completed frame clears on the next edge; a capture landing on that edge still sets its bit.
  always_comb begin
    codes_d = codes_q;
    valid_d = (valid_q == 4'hF) ? 4'd0 : valid_q;
    bad_d   = bad_q;
    aerr_d  = aerr_q;
    if (capture && (sel != 4'd0)) begin
      if (one_hot) begin
        for (int k = 0; k < 4; k++) begin
          if (sel[k]) begin
            codes_d[5*k +: 5] = code;
            valid_d[k]        = 1'b1;
          end
        end
        if (code == 5'd31) bad_d = 1'b1;
      end else begin
        aerr_d = 1'b1;
      end
    end
    frame_d = (valid_d == 4'hF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAIT;
      sample_q <= 11'h7FF;
      prev_q   <= 11'h7FF;
      cnt_q    <= 4'd0;
      codes_q  <= 20'd0;
      valid_q  <= 4'd0;
      frame_q  <= 1'b0;
      bad_q    <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= {an_in, seg_in};
      prev_q   <= sample_q;
      cnt_q    <= cnt_d;
      codes_q  <= codes_d;
      valid_q  <= valid_d;
      frame_q  <= frame_d;
      bad_q    <= bad_d;
      aerr_q   <= aerr_d;
    end
  end

  assign codes_out   = codes_q;
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign bad_pattern = bad_q;
  assign anode_err   = aerr_q;

endmodule

// File: tb/tb_segment_to_binary.sv
// Bench for segment_to_binary: directed table, hand-written timing/reset sequences,
// and randomized display traffic compared every cycle against a run-length reference model.
module tb_segment_to_binary;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in = 4'hF;
  logic [19:0] codes_out;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        bad_pattern;
  logic        anode_err;

  segment_to_binary #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .codes_out(codes_out), .digit_valid(digit_valid), .frame_valid(frame_valid),
    .bad_pattern(bad_pattern), .anode_err(anode_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] pats [24] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000, 7'b1110001, 7'b1111110,
    7'b1111111, 7'b0011000, 7'b1101010, 7'b1001000, 7'b1000001, 7'b0111001};

  // Reference model: tracks how long the applied pair has been held since it last changed.
  logic [19:0] m_codes;
  logic [3:0]  m_valid;
  logic        m_frame, m_bad, m_aerr, m_pend;
  logic [10:0] m_last, m_pval;
  int          m_run;

  function automatic logic [4:0] lookup(input logic [6:0] s);
    for (int i = 0; i < 24; i++)
      if (pats[i] == s) return 5'(i);
    return 5'd31;
  endfunction

  task automatic model_reset();
    m_codes = '0; m_valid = '0; m_frame = 0; m_bad = 0; m_aerr = 0;
    m_pend = 0; m_last = 11'h7FF; m_pval = 11'h7FF; m_run = 0;
  endtask

  task automatic model_edge(input logic [10:0] cur);
    logic [3:0] nv;
    logic [3:0] an;
    logic [4:0] c;
    int old_run;
    nv = (m_valid == 4'hF) ? 4'd0 : m_valid;
    if (m_pend) begin
      an = m_pval[10:7];
      if ($countones(~an) == 1) begin
        c = lookup(m_pval[6:0]);
        for (int k = 0; k < 4; k++)
          if (!an[k]) begin
            m_codes[5*k +: 5] = c;
            nv[k] = 1'b1;
          end
        if (c == 5'd31) m_bad = 1;
      end else if ($countones(~an) >= 2) begin
        m_aerr = 1;
      end
    end
    m_valid = nv;
    m_frame = (nv == 4'hF);
    old_run = m_run;
    if (cur != m_last) m_run = 1;
    else if (m_run > 0 && m_run < S) m_run = m_run + 1;
    m_pend = (m_run == S) && (old_run != S);
    m_last = cur;
    m_pval = cur;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] seg);
    an_in = an;
    seg_in = seg;
    @(posedge clk);
    model_edge({an, seg});
    #1;
    check("model_codes", 32'(codes_out), 32'(m_codes));
    check("model_valid", 32'(digit_valid), 32'(m_valid));
    check("model_frame", 32'(frame_valid), 32'(m_frame));
    check("model_bad", 32'(bad_pattern), 32'(m_bad));
    check("model_aerr", 32'(anode_err), 32'(m_aerr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_codes", 32'(codes_out), 32'd0);
    check("rst_valid", 32'(digit_valid), 32'd0);
    check("rst_frame", 32'(frame_valid), 32'd0);
    check("rst_bad", 32'(bad_pattern), 32'd0);
    check("rst_aerr", 32'(anode_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    logic [19:0] codes;
    logic [3:0]  valid;
    logic        bad;
    logic        aerr;
    int          frames;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int frames_seen;
    logic [3:0] ran;
    logic [6:0] rseg;
    int hold;

    tbl[0]  = '{4'hE, 7'b1001111, 6, 20'h00001, 4'b0001, 0, 0, 0};
    tbl[1]  = '{4'hD, 7'b0001000, 6, 20'h00141, 4'b0011, 0, 0, 0};
    tbl[2]  = '{4'hB, 7'b0011000, 6, 20'h04D41, 4'b0111, 0, 0, 0};
    tbl[3]  = '{4'h7, 7'b1000001, 6, 20'hB4D41, 4'b0000, 0, 0, 1};
    tbl[4]  = '{4'hB, 7'b0110000, 3, 20'hB4D41, 4'b0000, 0, 0, 0};
    tbl[5]  = '{4'hB, 7'b0000110, 3, 20'hB4D41, 4'b0000, 0, 0, 0};
    tbl[6]  = '{4'hB, 7'b0110000, 3, 20'hB4D41, 4'b0000, 0, 0, 0};
    tbl[7]  = '{4'hB, 7'b0000110, 3, 20'hB4D41, 4'b0000, 0, 0, 0};
    tbl[8]  = '{4'hB, 7'b0110000, 6, 20'hB3941, 4'b0100, 0, 0, 0};
    tbl[9]  = '{4'hF, 7'b0000000, 6, 20'hB3941, 4'b0100, 0, 0, 0};
    tbl[10] = '{4'hC, 7'b0000000, 8, 20'hB3941, 4'b0100, 0, 1, 0};
    tbl[11] = '{4'h7, 7'b1010101, 8, 20'hFB941, 4'b1100, 1, 1, 0};

    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Capture latency: nothing at edge 4, digit 2 in slot 0 at edge 5.
    for (int i = 0; i < S; i++) step(4'hE, 7'b0010010);
    check("lat_not_early", 32'(digit_valid), 32'd0);
    step(4'hE, 7'b0010010);
    check("lat_valid", 32'(digit_valid), 32'b0001);
    check("lat_code", 32'(codes_out[4:0]), 32'd2);

    do_reset();
    for (int v = 0; v < 12; v++) begin
      frames_seen = 0;
      for (int h = 0; h < tbl[v].hold; h++) begin
        step(tbl[v].an, tbl[v].seg);
        if (frame_valid) frames_seen++;
      end
      $display("vec %0d an=%b seg=%b codes=%h valid=%b bad=%b aerr=%b", v,
               tbl[v].an, tbl[v].seg, codes_out, digit_valid, bad_pattern, anode_err);
      check($sformatf("vec%0d_codes", v), 32'(codes_out), 32'(tbl[v].codes));
      check($sformatf("vec%0d_valid", v), 32'(digit_valid), 32'(tbl[v].valid));
      check($sformatf("vec%0d_bad", v), 32'(bad_pattern), 32'(tbl[v].bad));
      check($sformatf("vec%0d_aerr", v), 32'(anode_err), 32'(tbl[v].aerr));
      check($sformatf("vec%0d_frames", v), 32'(frames_seen), 32'(tbl[v].frames));
    end

    // Reset mid-track abandons the partial count; a full hold is needed afterwards.
    do_reset();
    step(4'hD, 7'b0000001);
    step(4'hD, 7'b0000001);
    do_reset();
    for (int i = 0; i < S; i++) step(4'hD, 7'b0000001);
    check("rst_mid_no_cap", 32'(digit_valid), 32'd0);
    step(4'hD, 7'b0000001);
    check("rst_mid_cap", 32'(digit_valid), 32'b0010);
    check("rst_mid_code", 32'(codes_out), 32'd0);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        8:       ran = 4'hF;
        9:       ran = 4'($urandom);
        default: ran = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 4) != 0) rseg = pats[$urandom_range(0, 23)];
      else rseg = 7'($urandom);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) step(ran, rseg);
      $display("rnd %0d an=%b seg=%b hold=%0d codes=%h valid=%b", n, ran, rseg, hold,
               codes_out, digit_valid);
      if ($urandom_range(0, 29) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
